// File: rtl/multiword_add_seq_pkg.sv
// Shared types and defaults for the sequential multi-word adder.
package add_seq_pkg;

    localparam int DEF_W = 16;
    localparam int DEF_K = 4;

    function automatic int cnt_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    localparam int CNT_W = cnt_w(DEF_K);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/multiword_add_seq_if.sv
// Request/result handshake bundle between requester and the sequential adder.
interface multiword_add_seq_if
    import add_seq_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int K = DEF_K
);
    logic             start_valid;
    logic             start_ready;
    logic [W*K-1:0]   x;
    logic [W*K-1:0]   y;
    logic             Cin;
    logic             res_valid;
    logic             res_ready;
    logic [W*K-1:0]   s;
    logic             Cout;
    logic             ovf;
    logic             busy;

    modport master (
        output start_valid, x, y, Cin, res_ready,
        input  start_ready, res_valid, s, Cout, ovf, busy
    );

    modport slave (
        input  start_valid, x, y, Cin, res_ready,
        output start_ready, res_valid, s, Cout, ovf, busy
    );

endinterface

// File: rtl/multiword_add_seq_cla.sv
// N-bit adder slice built from generate/propagate terms.
module cla_Nbit #(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         Cin,
    output logic [N-1:0] s,
    output logic         Cout
);

    logic [N-1:0] g;
    logic [N-1:0] p;

    always_comb begin
        logic cv;
        g  = x & y;
        p  = x ^ y;
        s  = '0;
        cv = Cin;
        // c[i+1] = g[i] | p[i]&c[i]; kept as a variable chain to avoid a self-referencing vector
        for (int unsigned i = 0; i < N; i++) begin
            s[i] = p[i] ^ cv;
            cv   = g[i] | (p[i] & cv);
        end
        Cout = cv;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Adds two W*K-bit operands over K cycles by reusing one W-bit slice adder.
module multiword_add_seq
    import add_seq_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int K = DEF_K
) (
    input logic               clk,
    input logic               rst_n,
    multiword_add_seq_if.slave bus
);

    localparam int            CW   = cnt_w(K);
    localparam int            MSB  = W*K - 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [W*K-1:0]  xr;
    logic [W*K-1:0]  yr;
    logic [W*K-1:0]  s_r;
    logic            cout_r;
    logic            ovf_r;

    logic [W-1:0]    xs;
    logic [W-1:0]    ys;
    logic [W-1:0]    ss;
    logic            sc;
    logic            accept;
    logic            step;

    assign xs = xr[cnt*W +: W];
    assign ys = yr[cnt*W +: W];

    cla_Nbit #(.N(W)) u_slice (
        .x    (xs),
        .y    (ys),
        .Cin  (carry),
        .s    (ss),
        .Cout (sc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: if (bus.start_valid) begin
                accept   = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: if (bus.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            xr     <= '0;
            yr     <= '0;
            s_r    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            xr    <= bus.x;
            yr    <= bus.y;
            carry <= bus.Cin;
            cnt   <= '0;
        end else if (step) begin
            s_r[cnt*W +: W] <= ss;
            carry           <= sc;
            cnt             <= cnt + 1'b1;
            if (cnt == LAST) begin
                cnt    <= '0;
                cout_r <= sc;
                ovf_r  <= (xr[MSB] == yr[MSB]) && (ss[W-1] != xr[MSB]);
            end
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.res_valid   = (state == DONE);
    assign bus.busy        = (state != IDLE);
    assign bus.s           = s_r;
    assign bus.Cout        = cout_r;
    assign bus.ovf         = ovf_r;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized self-checking bench for multiword_add_seq against an arithmetic reference.
module tb_multiword_add_seq;

    localparam int W = 16;
    localparam int K = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    multiword_add_seq_if #(.W(W), .K(K)) bus ();

    multiword_add_seq #(.W(W), .K(K)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] ref_sum(input logic [63:0] a, input logic [63:0] b, input logic ci);
        return {1'b0, a} + {1'b0, b} + 65'(ci);
    endfunction

    function automatic logic ref_ovf(input logic [63:0] a, input logic [63:0] b, input logic ci);
        logic signed [65:0] t;
        logic signed [65:0] hi;
        logic signed [65:0] lo;
        hi = 66'sh0_7FFF_FFFF_FFFF_FFFF;
        lo = -66'sh0_8000_0000_0000_0000;
        t  = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, ci});
        return (t > hi) || (t < lo);
    endfunction

    function automatic logic [63:0] rand64();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = 64'h7FFF_FFFF_FFFF_FFFF;
            3: v = 64'h8000_0000_0000_0000;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Entered one time unit after a rising edge with the block idle.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic ci,
                         input int stall, input bit early);
        logic [64:0] es;
        logic        eo;
        int          lat;
        es = ref_sum(a, b, ci);
        eo = ref_ovf(a, b, ci);
        bus.x = a;
        bus.y = b;
        bus.Cin = ci;
        bus.start_valid = 1'b1;
        check("start_ready_idle", bus.start_ready, 1);
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        bus.x = {$urandom, $urandom};
        bus.y = {$urandom, $urandom};
        bus.Cin = 1'($urandom);
        bus.res_ready = early;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.res_valid) break;
            if (lat == 1) begin
                check("busy_run", bus.busy, 1);
                check("start_ready_run", bus.start_ready, 0);
            end
        end
        check("latency", lat, K);
        check("sum", {bus.Cout, bus.s}, es);
        check("ovf", bus.ovf, eo);
        if (!early) begin
            for (int i = 0; i < stall; i++) begin
                bus.start_valid = (i == 1);
                if (i == 1) begin
                    bus.x = {$urandom, $urandom};
                    bus.y = {$urandom, $urandom};
                    bus.Cin = 1'($urandom);
                end
                @(posedge clk); #1;
                check("hold_valid", bus.res_valid, 1);
                check("hold_start_ready", bus.start_ready, 0);
                check("hold_sum", {bus.Cout, bus.s}, es);
                check("hold_ovf", bus.ovf, eo);
            end
            bus.start_valid = 1'b0;
            bus.res_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check("idle_valid", bus.res_valid, 0);
        check("idle_start_ready", bus.start_ready, 1);
        check("idle_busy", bus.busy, 0);
        check("idle_s_kept", bus.s, es[63:0]);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.Cin = 1'b0;
        #1;
        check("rst_start_ready", bus.start_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out", {bus.ovf, bus.Cout, bus.s}, 0);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 0, 1'b0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0, 1'b0);
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 1'b1);
        do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 10, 1'b0);

        // reset while the third slice is pending
        bus.x = {$urandom, $urandom};
        bus.y = {$urandom, $urandom};
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_start_ready", bus.start_ready, 1);
        check("mid_rst_res_valid", bus.res_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_out", {bus.ovf, bus.Cout, bus.s}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_valid", bus.res_valid, 0);
        end
        do_op(64'd5, 64'd7, 1'b0, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            do_op(rand64(), rand64(), 1'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
